msp_trace_ctrl: RTL and testbench
=================================

Name: msp_trace_ctrl

Overview:
- Instruction-trace capture sequencer for the MSP430 core debug path.
- Watches the decode strobe, PC, instruction register and IRQ detect, and stores one entry per decoded instruction into a circular buffer.
- Controls when capture starts (arm), when it stops (PC-match trigger plus a programmable post-trigger count), and how the buffer is read back oldest-first through a request/valid handshake.
- Lives beside the core debug monitor in the bench and debug hierarchy.

Parameters:
- DEPTH_LOG2, 4: buffer depth is 2**DEPTH_LOG2 entries (16).
- POST_W, 8: width of the post-trigger count.

Ports:
- mclk  in  1  Main system clock; single clock domain.
- puc_rst  in  1  Main system reset, synchronous, active-high.
- decode  in  1  Core decode strobe; one pulse per new instruction.
- pc  in  16  Program counter of the instruction being decoded.
- ir  in  16  Instruction register at decode.
- irq_detect  in  1  High when the current decode is an interrupt entry.
- arm  in  1  Pulse: clear the buffer and start capture.
- abort  in  1  Pulse: stop and return to IDLE.
- trig_en  in  1  Enables the PC-match trigger.
- trig_pc  in  16  Trigger PC value.
- force_trig  in  1  Pulse: immediate trigger.
- post_cnt  in  POST_W  Number of decodes captured after the trigger entry; sampled on trigger.
- rd_req  in  1  Read request, one entry per pulse.
- rd_valid  out  1  Read data valid, one cycle.
- rd_data  out  33  Read entry {irq, pc[15:0], ir[15:0]}; 49 bits with the optional feature.
- state  out  2  0=IDLE, 1=ARMED, 2=POST, 3=DONE.
- count  out  DEPTH_LOG2+1  Number of valid entries.
- triggered  out  1  Trigger seen in the current session.

Behaviour:
- Reset (puc_rst sampled high at a mclk edge):
  - state=IDLE.
  - wr_ptr=0, rd_ptr=0, count=0.
  - triggered=0, rd_valid=0, rd_data=0, post counter=0.
  - Buffer contents are don't-care.
- IDLE:
  - arm -> ARMED next cycle; ptrs=0, count=0, triggered=0.
  - decode is ignored.
- ARMED:
  - Each decode writes {irq_detect,pc,ir} at wr_ptr; wr_ptr+1 wraps modulo depth.
  - count+1 saturates at depth; when full the oldest entry is overwritten.
  - Trigger = force_trig OR (trig_en AND decode AND pc==trig_pc).
  - On trigger: triggered=1 and post counter loads post_cnt.
  - A PC-match trigger's own decode is captured in the same cycle.
  - post_cnt==0 -> DONE next cycle; otherwise -> POST.
  - force_trig without a decode captures nothing extra.
- POST:
  - Each decode is captured as in ARMED and decrements the post counter.
  - The decode that takes the counter 1->0 is captured, then the block goes to DONE.
  - Further triggers are ignored.
- DONE:
  - Capture stops.
  - rd_ptr = wr_ptr - count (mod depth), latched on entry to DONE.
  - rd_req with count>0: next cycle rd_valid=1 and rd_data = entry at rd_ptr; rd_ptr+1 and count-1 take effect on that same edge.
  - rd_req while rd_valid=1 is accepted, giving back-to-back reads at one entry per cycle.
  - rd_req with count==0 -> no rd_valid; state goes to IDLE next cycle.
  - When count reaches 0 after a read, state stays DONE until the next rd_req or arm.
- rd_req outside DONE is ignored (rd_valid stays 0).
- Priority within one cycle:
  - puc_rst > abort > arm > trigger > capture > read.
  - abort in any state -> IDLE; entries and count are kept, so a subsequent arm clears them.
  - arm in ARMED, POST or DONE restarts the session (clear, then ARMED).
- decode and a trigger in the same cycle as arm: the decode is not captured; capture begins on the next cycle.
- rd_data holds its value between reads; rd_valid is a single-cycle pulse.
- Depth 1 (DEPTH_LOG2=0) is not supported; DEPTH_LOG2 must be >=1.

Optional Feature:
- MSP_TRACE_TSTAMP_EN defined:
  - A 16-bit mclk cycle counter is kept; it is cleared on arm and on each captured decode, saturates at 16'hFFFF, and is held at 0 in IDLE.
  - Each entry gains a 16-bit field holding the cycles since the previous captured decode (0 for the first entry after arm).
  - rd_data is 49 bits, {delta[15:0], irq, pc, ir}.
- Not defined: no counter; rd_data is 33 bits.

Test Plan:
- Basic trace:
  - Stimulus: arm; trig_en=1, trig_pc=16'hF010, post_cnt=2; decodes at pc F000, F002, F010, F012, F014, F016.
  - Required: DONE after F014; count=5; reads return F000, F002, F010, F012, F014 in order, each with its ir; F016 not captured.
- Wrap:
  - Stimulus: DEPTH_LOG2=4; 20 decodes at pc 0x100+2n; force_trig with post_cnt=0.
  - Required: count=16; first read pc=0x108, last read pc=0x126.
- Back-to-back read:
  - Stimulus: rd_req held for 4 cycles after the basic trace.
  - Required: 4 consecutive rd_valid pulses, count 5->1; a 6th rd_req at count=0 gives no rd_valid and state goes to IDLE.
- Priority:
  - Stimulus: arm and abort in the same cycle while in POST.
  - Required: IDLE, triggered unchanged.
  - Stimulus: arm and decode in the same cycle.
  - Required: count=0 the cycle after.
- Reset mid-operation:
  - Stimulus: puc_rst high for 1 cycle in POST with count=7.
  - Required: next cycle state=0, count=0, triggered=0, rd_valid=0.
  - Reset is synchronous: asserting puc_rst between edges changes nothing until the edge.
- IRQ entry plus optional feature:
  - Stimulus: decode with irq_detect=1 at 5 cycles after the previous decode, with MSP_TRACE_TSTAMP_EN defined.
  - Required: entry has irq=1 and delta=5; first entry after arm has delta=0.

Source files
------------

// File: rtl/msp_trace_ctrl_if.sv
// msp_trace_ctrl_if: capture, trigger, readback and status signals of the
// MSP430 instruction-trace sequencer.
// Optional macro MSP_TRACE_TSTAMP_EN widens rd_data from 33 to 49 bits.
interface msp_trace_ctrl_if #(
    parameter int DEPTH_LOG2 = 4,
    parameter int POST_W     = 8
);
`ifdef MSP_TRACE_TSTAMP_EN
    localparam int ENTRY_W = 49;
`else
    localparam int ENTRY_W = 33;
`endif

    // Core observation
    logic                  decode;
    logic [15:0]           pc;
    logic [15:0]           ir;
    logic                  irq_detect;
    // Session control
    logic                  arm;
    logic                  abort;
    logic                  trig_en;
    logic [15:0]           trig_pc;
    logic                  force_trig;
    logic [POST_W-1:0]     post_cnt;
    // Readback
    logic                  rd_req;
    logic                  rd_valid;
    logic [ENTRY_W-1:0]    rd_data;
    // Status
    logic [1:0]            state;
    logic [DEPTH_LOG2:0]   count;
    logic                  triggered;

    modport master (
        output decode, pc, ir, irq_detect, arm, abort, trig_en, trig_pc,
               force_trig, post_cnt, rd_req,
        input  rd_valid, rd_data, state, count, triggered
    );

    modport slave (
        input  decode, pc, ir, irq_detect, arm, abort, trig_en, trig_pc,
               force_trig, post_cnt, rd_req,
        output rd_valid, rd_data, state, count, triggered
    );
endinterface

// File: rtl/msp_trace_ctrl.sv
// msp_trace_ctrl: instruction-trace capture sequencer for the MSP430 debug path.
// Stores {irq, pc, ir} per decoded instruction in a circular buffer, stops a
// programmable number of decodes after a PC-match or forced trigger, and
// returns the buffer oldest-first through a rd_req/rd_valid handshake.
// Optional macro MSP_TRACE_TSTAMP_EN adds a 16-bit inter-decode cycle delta
// to every entry ({delta, irq, pc, ir}).
module msp_trace_ctrl #(
    parameter int DEPTH_LOG2 = 4,   // must be >= 1
    parameter int POST_W     = 8
) (
    input  logic             mclk,
    input  logic             puc_rst,
    msp_trace_ctrl_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 1;
`ifdef MSP_TRACE_TSTAMP_EN
    localparam int ENTRY_W = 49;
`else
    localparam int ENTRY_W = 33;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                 state_q;
    logic [DEPTH_LOG2-1:0]  wr_ptr_q;
    logic [DEPTH_LOG2-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]       count_q;
    logic [POST_W-1:0]      post_q;
    logic                   triggered_q;
    logic                   rd_valid_q;
    logic [ENTRY_W-1:0]     rd_data_q;
    logic [ENTRY_W-1:0]     mem [DEPTH];

    logic                   cap;
    logic                   trig_hit;
    logic [DEPTH_LOG2-1:0]  wr_ptr_nxt;
    logic [CNT_W-1:0]       count_nxt;
    logic [DEPTH_LOG2-1:0]  rd_ptr_done;
    logic [ENTRY_W-1:0]     entry;

`ifdef MSP_TRACE_TSTAMP_EN
    logic [15:0]            ts_q;
    logic                   first_q;
    logic [15:0]            delta;

    // Cycle delta of this decode relative to the previous captured one.
    always_comb begin
        delta = '0;
        if (!first_q)
            delta = (ts_q == 16'hFFFF) ? 16'hFFFF : ts_q + 16'd1;
    end

    // Inter-decode cycle counter: cleared on arm/capture, held at 0 in IDLE.
    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            ts_q    <= '0;
            first_q <= 1'b1;
        end else if (bus.abort) begin
            ts_q    <= '0;
        end else if (bus.arm) begin
            ts_q    <= '0;
            first_q <= 1'b1;
        end else if (cap) begin
            ts_q    <= '0;
            first_q <= 1'b0;
        end else if (state_q == ST_IDLE) begin
            ts_q    <= '0;
        end else if (ts_q != 16'hFFFF) begin
            ts_q    <= ts_q + 16'd1;
        end
    end
`endif

    // Capture qualification and next write-side pointer/count values.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        cap         = 1'b0;
        trig_hit    = bus.force_trig |
                      (bus.trig_en & bus.decode & (bus.pc == bus.trig_pc));
        if ((state_q == ST_ARMED || state_q == ST_POST) && !bus.abort && !bus.arm)
            cap = bus.decode;
        wr_ptr_nxt  = cap ? wr_ptr_q + 1'b1 : wr_ptr_q;
        count_nxt   = (cap && count_q != CNT_W'(DEPTH)) ? count_q + 1'b1 : count_q;
        // Oldest entry once this cycle's capture (if any) has landed.
        rd_ptr_done = wr_ptr_nxt - count_nxt[DEPTH_LOG2-1:0];
`ifdef MSP_TRACE_TSTAMP_EN
        entry       = {delta, bus.irq_detect, bus.pc, bus.ir};
`else
        entry       = {bus.irq_detect, bus.pc, bus.ir};
`endif
    end

    // Trace buffer write port.
    always_ff @(posedge mclk) begin
        // NOTE: the buffer has no reset; its contents are don't-care until written, and count_q guards every read.
        if (cap)
            mem[wr_ptr_q] <= entry;
    end

    // Session FSM with registered status and readback outputs.
    always_ff @(posedge mclk) begin
        // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (puc_rst) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            post_q      <= '0;
            triggered_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            rd_valid_q <= 1'b0;
            if (bus.abort) begin
                state_q <= ST_IDLE;
            end else if (bus.arm) begin
                state_q     <= ST_ARMED;
                wr_ptr_q    <= '0;
                rd_ptr_q    <= '0;
                count_q     <= '0;
                post_q      <= '0;
                triggered_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: ;
                    ST_ARMED: begin
                        wr_ptr_q <= wr_ptr_nxt;
                        count_q  <= count_nxt;
                        if (trig_hit) begin
                            triggered_q <= 1'b1;
                            post_q      <= bus.post_cnt;
                            if (bus.post_cnt == '0) begin
                                state_q  <= ST_DONE;
                                rd_ptr_q <= rd_ptr_done;
                            end else begin
                                state_q  <= ST_POST;
                            end
                        end
                    end
                    ST_POST: begin
                        if (cap) begin
                            wr_ptr_q <= wr_ptr_nxt;
                            count_q  <= count_nxt;
                            post_q   <= post_q - 1'b1;
                            if (post_q == POST_W'(1)) begin
                                state_q  <= ST_DONE;
                                rd_ptr_q <= rd_ptr_done;
                            end
                        end
                    end
                    ST_DONE: begin
                        if (bus.rd_req) begin
                            if (count_q != '0) begin
                                rd_valid_q <= 1'b1;
                                rd_data_q  <= mem[rd_ptr_q];
                                rd_ptr_q   <= rd_ptr_q + 1'b1;
                                count_q    <= count_q - 1'b1;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.state     = state_q;
    assign bus.count     = count_q;
    assign bus.triggered = triggered_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;

endmodule

// File: tb/tb_msp_trace_ctrl.sv
// tb_msp_trace_ctrl: scoreboard bench for msp_trace_ctrl. Captured entries
// are pushed to a queue modelling the 16-deep circular buffer and popped on
// every rd_valid. Build with MSP_TRACE_TSTAMP_EN to cover the delta field.
`timescale 1ns/1ps
module tb_msp_trace_ctrl;
    localparam int DEPTH_LOG2 = 4;
    localparam int POST_W     = 8;
    localparam int DEPTH      = 1 << DEPTH_LOG2;
`ifdef MSP_TRACE_TSTAMP_EN
    localparam int ENTRY_W = 49;
`else
    localparam int ENTRY_W = 33;
`endif

    logic mclk = 1'b0;
    logic puc_rst;
    always #5 mclk = ~mclk;

    msp_trace_ctrl_if #(.DEPTH_LOG2(DEPTH_LOG2), .POST_W(POST_W)) bus ();

    msp_trace_ctrl #(.DEPTH_LOG2(DEPTH_LOG2), .POST_W(POST_W)) dut (
        .mclk    (mclk),
        .puc_rst (puc_rst),
        .bus     (bus.slave)
    );

    int                 vectors     = 0;
    int                 miscompares = 0;
    logic [ENTRY_W-1:0] exp_q [$];
    logic [ENTRY_W-1:0] last_exp    = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge mclk);
        #1;
    endtask

    function automatic logic [15:0] ir_of(input logic [15:0] pc);
        return pc ^ 16'hA5C3;
    endfunction

    function automatic logic [ENTRY_W-1:0] mk(input logic [15:0] delta, input logic irq,
                                              input logic [15:0] pc, input logic [15:0] ir);
        return ENTRY_W'({delta, irq, pc, ir});
    endfunction

    // Circular-buffer model: keep only the newest DEPTH entries.
    task automatic sb_push(input logic [ENTRY_W-1:0] e);
        if (exp_q.size() == DEPTH)
            void'(exp_q.pop_front());
        exp_q.push_back(e);
    endtask

    task automatic do_decode(input logic [15:0] pc, input logic irq, input bit captured,
                             input logic [15:0] delta);
        bus.decode     = 1'b1;
        bus.pc         = pc;
        bus.ir         = ir_of(pc);
        bus.irq_detect = irq;
        if (captured)
            sb_push(mk(delta, irq, pc, ir_of(pc)));
        cyc();
        bus.decode     = 1'b0;
        bus.irq_detect = 1'b0;
    endtask

    task automatic arm_pulse();
        bus.arm = 1'b1;
        cyc();
        bus.arm = 1'b0;
        exp_q.delete();
    endtask

    // Compare the current rd_valid/rd_data against the scoreboard head.
    task automatic check_read(input string tag);
        logic [ENTRY_W-1:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        last_exp = e;
        check({tag, "_valid"}, 64'(bus.rd_valid), 64'(1));
        check({tag, "_data"}, 64'(bus.rd_data), 64'(e));
    endtask

    task automatic read_one(input string tag);
        bus.rd_req = 1'b1;
        cyc();
        bus.rd_req = 1'b0;
        check_read(tag);
    endtask

    task automatic force_trigger(input logic [POST_W-1:0] pcnt);
        bus.force_trig = 1'b1;
        bus.post_cnt   = pcnt;
        cyc();
        bus.force_trig = 1'b0;
    endtask

    initial begin
        puc_rst        = 1'b1;
        bus.decode     = 1'b0;
        bus.pc         = '0;
        bus.ir         = '0;
        bus.irq_detect = 1'b0;
        bus.arm        = 1'b0;
        bus.abort      = 1'b0;
        bus.trig_en    = 1'b0;
        bus.trig_pc    = '0;
        bus.force_trig = 1'b0;
        bus.post_cnt   = '0;
        bus.rd_req     = 1'b0;
        cyc();
        cyc();
        puc_rst = 1'b0;

        // Reset state
        check("rst_state", 64'(bus.state), 64'(0));
        check("rst_count", 64'(bus.count), 64'(0));
        check("rst_trig", 64'(bus.triggered), 64'(0));
        check("rst_rd_valid", 64'(bus.rd_valid), 64'(0));
        check("rst_rd_data", 64'(bus.rd_data), 64'(0));

        // rd_req and decode are ignored in IDLE
        bus.rd_req = 1'b1;
        cyc();
        bus.rd_req = 1'b0;
        check("idle_rd_valid", 64'(bus.rd_valid), 64'(0));
        do_decode(16'hE000, 1'b0, 1'b0, 16'd0);
        check("idle_count", 64'(bus.count), 64'(0));
        check("idle_state", 64'(bus.state), 64'(0));

        // Basic trace: PC-match trigger at F010, two post-trigger decodes
        arm_pulse();
        check("basic_armed", 64'(bus.state), 64'(1));
        bus.trig_en  = 1'b1;
        bus.trig_pc  = 16'hF010;
        bus.post_cnt = 8'd2;
        do_decode(16'hF000, 1'b0, 1'b1, 16'd0);
        do_decode(16'hF002, 1'b0, 1'b1, 16'd1);
        check("basic_pre_trig", 64'(bus.triggered), 64'(0));
        do_decode(16'hF010, 1'b0, 1'b1, 16'd1);
        check("basic_post_state", 64'(bus.state), 64'(2));
        check("basic_triggered", 64'(bus.triggered), 64'(1));
        do_decode(16'hF012, 1'b0, 1'b1, 16'd1);
        check("basic_still_post", 64'(bus.state), 64'(2));
        do_decode(16'hF014, 1'b0, 1'b1, 16'd1);
        check("basic_done", 64'(bus.state), 64'(3));
        do_decode(16'hF016, 1'b0, 1'b0, 16'd1);
        check("basic_count", 64'(bus.count), 64'(5));

        // Back-to-back reads with rd_req held for 4 cycles
        bus.rd_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check_read($sformatf("b2b_%0d", i));
            check($sformatf("b2b_count_%0d", i), 64'(bus.count), 64'(4 - i));
        end
        bus.rd_req = 1'b0;
        cyc();
        check("b2b_pulse_end", 64'(bus.rd_valid), 64'(0));
        check("b2b_data_hold", 64'(bus.rd_data), 64'(last_exp));
        read_one("b2b_4");
        check("b2b_empty_count", 64'(bus.count), 64'(0));
        cyc();
        check("b2b_empty_stays_done", 64'(bus.state), 64'(3));
        bus.rd_req = 1'b1;
        cyc();
        bus.rd_req = 1'b0;
        check("b2b_extra_no_valid", 64'(bus.rd_valid), 64'(0));
        check("b2b_extra_idle", 64'(bus.state), 64'(0));

        // Wrap: 20 decodes into a 16-deep buffer, then force_trig with post_cnt=0
        arm_pulse();
        bus.trig_en = 1'b0;
        for (int n = 0; n < 20; n++)
            do_decode(16'(16'h0100 + 2 * n), 1'((n % 3) == 0), 1'b1, (n == 0) ? 16'd0 : 16'd1);
        check("wrap_armed_count", 64'(bus.count), 64'(16));
        force_trigger(8'd0);
        check("wrap_done", 64'(bus.state), 64'(3));
        check("wrap_count", 64'(bus.count), 64'(16));
        for (int i = 0; i < 16; i++)
            read_one($sformatf("wrap_rd_%0d", i));
        check("wrap_drained", 64'(bus.count), 64'(0));

        // Priority: arm+abort in POST, arm+decode+trigger, force_trig without decode
        arm_pulse();
        bus.trig_en  = 1'b1;
        bus.trig_pc  = 16'h0200;
        bus.post_cnt = 8'd5;
        do_decode(16'h01FE, 1'b0, 1'b1, 16'd0);
        do_decode(16'h0200, 1'b0, 1'b1, 16'd1);
        do_decode(16'h0202, 1'b0, 1'b1, 16'd1);
        check("prio_in_post", 64'(bus.state), 64'(2));
        bus.arm   = 1'b1;
        bus.abort = 1'b1;
        cyc();
        bus.arm   = 1'b0;
        bus.abort = 1'b0;
        check("prio_abort_idle", 64'(bus.state), 64'(0));
        check("prio_abort_trig_kept", 64'(bus.triggered), 64'(1));
        check("prio_abort_count_kept", 64'(bus.count), 64'(3));

        bus.arm        = 1'b1;
        bus.decode     = 1'b1;
        bus.pc         = 16'h0200;
        bus.ir         = ir_of(16'h0200);
        bus.force_trig = 1'b1;
        cyc();
        bus.arm        = 1'b0;
        bus.decode     = 1'b0;
        bus.force_trig = 1'b0;
        exp_q.delete();
        check("prio_arm_dec_count", 64'(bus.count), 64'(0));
        check("prio_arm_dec_state", 64'(bus.state), 64'(1));
        check("prio_arm_dec_trig", 64'(bus.triggered), 64'(0));
        do_decode(16'h0210, 1'b0, 1'b1, 16'd0);
        check("prio_first_capture", 64'(bus.count), 64'(1));
        force_trigger(8'd1);
        check("prio_force_post", 64'(bus.state), 64'(2));
        check("prio_force_no_capture", 64'(bus.count), 64'(1));
        do_decode(16'h0212, 1'b1, 1'b1, 16'd2);
        check("prio_done", 64'(bus.state), 64'(3));
        check("prio_done_count", 64'(bus.count), 64'(2));
        read_one("prio_rd_0");
        read_one("prio_rd_1");

        // Reset mid-operation in POST with 7 entries
        arm_pulse();
        bus.trig_pc  = 16'h0406;
        bus.post_cnt = 8'd10;
        for (int n = 0; n < 7; n++)
            do_decode(16'(16'h0400 + 2 * n), 1'b0, 1'b1, (n == 0) ? 16'd0 : 16'd1);
        check("mid_post", 64'(bus.state), 64'(2));
        check("mid_count", 64'(bus.count), 64'(7));
        @(negedge mclk);
        puc_rst = 1'b1;
        #1;
        check("mid_sync_state", 64'(bus.state), 64'(2));
        check("mid_sync_count", 64'(bus.count), 64'(7));
        cyc();
        puc_rst = 1'b0;
        exp_q.delete();
        check("mid_rst_state", 64'(bus.state), 64'(0));
        check("mid_rst_count", 64'(bus.count), 64'(0));
        check("mid_rst_trig", 64'(bus.triggered), 64'(0));
        check("mid_rst_valid", 64'(bus.rd_valid), 64'(0));

        // IRQ entry 5 cycles after the previous decode (delta field when enabled)
        arm_pulse();
        bus.trig_en = 1'b0;
        cyc();
        cyc();
        do_decode(16'h0500, 1'b0, 1'b1, 16'd0);
        repeat (4) cyc();
        do_decode(16'h0504, 1'b1, 1'b1, 16'd5);
        force_trigger(8'd0);
        check("irq_done", 64'(bus.state), 64'(3));
        check("irq_count", 64'(bus.count), 64'(2));
        read_one("irq_rd_0");
        read_one("irq_rd_1");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
